// File: rtl/grid_row_loader_if.sv
// Byte-stream input and row-memory write port shared by the grid row loader
// and whatever feeds it and consumes its writes.
interface grid_row_loader_if #(
  parameter int ROW_WIDTH = 34,
  parameter int NUM_ROWS  = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [7:0]                  in_data;
  logic                        in_last;
  logic                        we;
  logic [$clog2(NUM_ROWS)-1:0] w_addr;
  logic [ROW_WIDTH-1:0]        w_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, we, w_addr, w_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, we, w_addr, w_data
  );
endinterface

// File: rtl/grid_row_loader.sv
// Packs an ASCII '@'/'.' grid, one text line per row, into zero-padded row
// bitmaps and writes them to the row memory; reports grid size and errors.
//
// state   | meaning
// S_IDLE  | waiting for the first start
// S_LOAD  | accepting bytes into row_buf
// S_WRITE | one-cycle row write (we high), input stalled
// S_DONE  | stream finished cleanly, load_done held
// S_ERR   | malformed input, err/err_code held, no further writes
module grid_row_loader #(
  parameter int ROW_WIDTH = 34,
  parameter int NUM_ROWS  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  grid_row_loader_if.slave                bus,
  output logic                            load_done,
  output logic                            err,
  output logic [2:0]                      err_code,
  output logic [$clog2(NUM_ROWS+1)-1:0]   rows,
  output logic [$clog2(ROW_WIDTH)-1:0]    cols
);

  localparam int COLS = ROW_WIDTH - 2;
  localparam int AW   = $clog2(NUM_ROWS);
  localparam int RW   = $clog2(NUM_ROWS + 1);
  localparam int CW   = $clog2(ROW_WIDTH);
  localparam logic [ROW_WIDTH-1:0] PAD_MASK = {1'b0, {COLS{1'b1}}, 1'b0};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        col, col_next, bit_idx;
  logic [ROW_WIDTH-1:0] row_buf, buf_next;
  logic                 fin;
  logic                 arm, accept, wr_req, done_set, err_set;
  logic [2:0]           err_code_next;
  logic                 pix, nl, bad, flush;

  assign bus.in_ready = (state == S_LOAD);
  assign accept       = bus.in_valid && (state == S_LOAD);
  assign bit_idx      = col + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    arm           = 1'b0;
    wr_req        = 1'b0;
    done_set      = 1'b0;
    err_set       = 1'b0;
    err_code_next = 3'd0;
    buf_next      = row_buf;
    col_next      = col;
    pix           = 1'b0;
    nl            = 1'b0;
    bad           = 1'b0;
    flush         = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          arm        = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          case (bus.in_data)
            8'h40, 8'h2E: pix = 1'b1;
            8'h0D:        ;
            8'h0A:        nl  = 1'b1;
            default:      bad = 1'b1;
          endcase
          if (bad) begin
            err_set       = 1'b1;
            err_code_next = 3'd1;
          end else if (pix && col == CW'(COLS)) begin
            err_set       = 1'b1;
            err_code_next = 3'd2;
          end else begin
            if (pix) begin
              buf_next[bit_idx] = (bus.in_data == 8'h40);
              col_next          = bit_idx;
            end
            // A last byte flushes a pending row even without a newline.
            flush = (nl || bus.in_last) && (col_next != '0);
            if (flush) begin
              if (rows == RW'(NUM_ROWS)) begin
                err_set       = 1'b1;
                err_code_next = 3'd4;
              end else if (rows != '0 && col_next != cols) begin
                err_set       = 1'b1;
                err_code_next = 3'd3;
              end else begin
                wr_req     = 1'b1;
                state_next = S_WRITE;
              end
            end else if (bus.in_last) begin
              done_set   = 1'b1;
              state_next = S_DONE;
            end
          end
          if (err_set) state_next = S_ERR;
        end
      end
      S_WRITE: begin
        done_set   = fin;
        state_next = fin ? S_DONE : S_LOAD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.we     <= 1'b0;
      bus.w_addr <= '0;
      bus.w_data <= '0;
      load_done  <= 1'b0;
      err        <= 1'b0;
      err_code   <= 3'd0;
      rows       <= '0;
      cols       <= '0;
      col        <= '0;
      row_buf    <= '0;
      fin        <= 1'b0;
    end else begin
      bus.we <= wr_req;
      if (arm) begin
        load_done <= 1'b0;
        err       <= 1'b0;
        err_code  <= 3'd0;
        rows      <= '0;
        cols      <= '0;
        col       <= '0;
        row_buf   <= '0;
        fin       <= 1'b0;
      end
      // rows advances with the write so it already counts the row while we is high.
      if (wr_req) begin
        bus.w_addr <= rows[AW-1:0];
        bus.w_data <= buf_next & PAD_MASK;
        if (rows == '0) cols <= col_next;
        rows       <= rows + RW'(1);
        col        <= '0;
        row_buf    <= '0;
        fin        <= bus.in_last;
      end else if (accept) begin
        col     <= col_next;
        row_buf <= buf_next;
      end
      if (err_set) begin
        err      <= 1'b1;
        err_code <= err_code_next;
      end
      if (done_set) load_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_grid_row_loader.sv
// Scoreboard bench for grid_row_loader with a 4-column, 4-row grid: expected
// row writes are queued as lines are sent and popped as the DUT writes them.
module tb_grid_row_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       load_done;
  logic       err;
  logic [2:0] err_code;
  logic [2:0] rows;
  logic [2:0] cols;

  grid_row_loader_if #(.ROW_WIDTH(6), .NUM_ROWS(4)) bus ();

  grid_row_loader #(.ROW_WIDTH(6), .NUM_ROWS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .load_done (load_done),
    .err       (err),
    .err_code  (err_code),
    .rows      (rows),
    .cols      (cols)
  );

  always #5 clk = ~clk;

  int         n_vec  = 0;
  int         n_bad  = 0;
  int         wr_cnt = 0;
  logic       prev_we = 1'b0;
  logic [7:0] sb[$];   // {addr[1:0], data[5:0]}
  logic [7:0] exp_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wr_cnt++;
      chk("bubble", 32'(bus.in_ready), 0);
      chk("we_pulse", 32'(prev_we), 0);
      if (sb.size() == 0) begin
        chk("we_unexpected", 32'(bus.we), 0);
      end else begin
        exp_w = sb.pop_front();
        chk("w_addr", 32'(bus.w_addr), 32'(exp_w[7:6]));
        chk("w_data", 32'(bus.w_data), 32'(exp_w[5:0]));
      end
    end
    prev_we = bus.we;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) chk("accept_timeout", 32'(bus.in_ready), 1);
  endtask

  task automatic send_str(input string s, input logic last, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      if (gap > 0) repeat ($urandom_range(gap, 0)) tick();
      send_byte(s[i], last && (i == s.len() - 1));
    end
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start  = 1'b0;
    wr_cnt = 0;
    chk("ready_after_start", 32'(bus.in_ready), 1);
  endtask

  task automatic check_done(input int r, input int c, input int wrs);
    for (int i = 0; i < 30 && !(load_done || err); i++) tick();
    chk("load_done", 32'(load_done), 1);
    chk("no_err", 32'(err), 0);
    chk("rows", 32'(rows), r);
    chk("cols", 32'(cols), c);
    chk("sb_empty", 32'(sb.size()), 0);
    chk("wr_cnt", wr_cnt, wrs);
  endtask

  // Called right after the offending byte is accepted: err must be up now.
  task automatic check_err(input int code, input int r, input int wrs);
    chk("err", 32'(err), 1);
    chk("err_code", 32'(err_code), code);
    chk("err_ready", 32'(bus.in_ready), 0);
    chk("err_done", 32'(load_done), 0);
    chk("err_rows", 32'(rows), r);
    chk("err_sb", 32'(sb.size()), 0);
    chk("err_wr_cnt", wr_cnt, wrs);
  endtask

  task automatic check_reset_vals();
    chk("rst_ready", 32'(bus.in_ready), 0);
    chk("rst_we", 32'(bus.we), 0);
    chk("rst_w_addr", 32'(bus.w_addr), 0);
    chk("rst_w_data", 32'(bus.w_data), 0);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_rows", 32'(rows), 0);
    chk("rst_cols", 32'(cols), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    repeat (2) tick();
    check_reset_vals();
    rst = 1'b0;
    tick();

    // Two full rows, last on the final newline; checks bubble and done timing.
    arm();
    sb.push_back({2'd0, 6'h1A});
    sb.push_back({2'd1, 6'h04});
    send_str("@.@@\n", 1'b0, 0);
    chk("nl_we_n1", 32'(bus.we), 1);
    chk("nl_ready_n1", 32'(bus.in_ready), 0);
    tick();
    chk("nl_ready_n2", 32'(bus.in_ready), 1);
    send_str(".@..", 1'b0, 0);
    send_byte(8'h0A, 1'b1);
    chk("last_we_n1", 32'(bus.we), 1);
    chk("last_done_n1", 32'(load_done), 0);
    tick();
    chk("last_done_n2", 32'(load_done), 1);
    check_done(2, 4, 2);

    // CR ignored, final row flushed by in_last without newline.
    arm();
    sb.push_back({2'd0, 6'h06});
    sb.push_back({2'd1, 6'h06});
    send_str("@@\015\n@@", 1'b1, 0);
    check_done(2, 2, 2);

    // Blank lines dropped.
    arm();
    sb.push_back({2'd0, 6'h06});
    send_str("\n\n@@\n", 1'b1, 0);
    check_done(1, 2, 1);

    // Random valid gaps do not change the write count.
    arm();
    sb.push_back({2'd0, 6'h02});
    sb.push_back({2'd1, 6'h04});
    send_str("@.\n.@\n", 1'b1, 3);
    check_done(2, 2, 2);

    // Column overflow on the fifth pixel.
    arm();
    send_str("@@@@@", 1'b0, 0);
    check_err(2, 0, 0);

    // Ragged second row.
    arm();
    sb.push_back({2'd0, 6'h06});
    send_str("@@\n@\n", 1'b0, 0);
    check_err(3, 1, 1);

    // Bad character.
    arm();
    send_str("@x", 1'b0, 0);
    check_err(1, 0, 0);

    // Row overflow on the fifth row.
    arm();
    for (int i = 0; i < 4; i++) sb.push_back({2'(i), 6'h02});
    repeat (5) send_str("@...\n", 1'b0, 0);
    check_err(4, 4, 4);

    // Reset mid-row, then a clean reload.
    arm();
    sb.push_back({2'd0, 6'h1A});
    send_str("@.@@\n", 1'b0, 0);
    send_str(".@", 1'b0, 0);
    chk("pre_rst_rows", 32'(rows), 1);
    rst = 1'b1;
    tick();
    check_reset_vals();
    rst = 1'b0;
    tick();
    arm();
    sb.push_back({2'd0, 6'h18});
    send_str("..@@\n", 1'b1, 0);
    check_done(1, 4, 1);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
